// File: rtl/branch_predict_unit_if.sv
// Bus between the pipeline and the branch predictor.
//   master : core side (IF fetch PC, MEM-stage resolution, flush request)
//   slave  : predictor side (lookup results, redirect decision, statistics)
// Signal names keep the original *_i / *_o names as seen from the predictor.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN = 32
);
  // control / status
  logic            flush_i;
  logic            ready_o;
  // IF-stage lookup
  logic [XLEN-1:0] if_pc_i;
  logic            pred_hit_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  // MEM-stage resolution
  logic            upd_valid_i;
  logic            upd_is_brj_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic            upd_pred_taken_i;
  logic [XLEN-1:0] upd_pred_target_i;
  // redirect decision
  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;
  // statistics
  logic [31:0]     brj_cnt_o;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output flush_i, if_pc_i,
    output upd_valid_i, upd_is_brj_i, upd_pc_i, upd_taken_i, upd_target_i,
    output upd_pred_taken_i, upd_pred_target_i,
    input  ready_o, pred_hit_o, pred_taken_o, pred_target_o,
    input  mispredict_o, redirect_pc_o, brj_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  flush_i, if_pc_i,
    input  upd_valid_i, upd_is_brj_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  upd_pred_taken_i, upd_pred_target_i,
    output ready_o, pred_hit_o, pred_taken_o, pred_target_o,
    output mispredict_o, redirect_pc_o, brj_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor and misprediction detector.
// Direct-mapped BTB with saturating direction counters, looked up
// combinationally by IF and trained by MEM-stage branch/jump results.
// The MEM results also produce the redirect/flush decision.
//
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : branch_predict_unit_if.slave
//            flush_i / ready_o          table invalidate, table initialised
//            if_pc_i -> pred_*          zero-latency lookup
//            upd_*                      resolved branch/jump from MEM
//            mispredict_o, redirect_pc_o  redirect decision
//            brj_cnt_o, mispred_cnt_o   wrapping 32-bit statistics
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_ENTRIES = 64,
  parameter int unsigned CNT_W       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  branch_predict_unit_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sweep_idx, sweep_nxt;
  logic              clr_en;
  logic              trn_en;

  // BTB storage; valid bits are cleared by the INIT sweep, so no reset here
  logic              btb_valid [NUM_ENTRIES];
  logic [TAG_W-1:0]  btb_tag   [NUM_ENTRIES];
  logic [XLEN-1:0]   btb_tgt   [NUM_ENTRIES];
  logic [CNT_W-1:0]  btb_cnt   [NUM_ENTRIES];

  logic [31:0]       brj_cnt;
  logic [31:0]       mispred_cnt;

  // ---------------------------------------------------------------------
  // Resolution / misprediction (combinational in every state)
  // ---------------------------------------------------------------------
  logic              brj_res;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;

  assign brj_res = bus.upd_valid_i & bus.upd_is_brj_i;

  always_comb begin
    mispredict  = brj_res &
                  ((bus.upd_pred_taken_i != bus.upd_taken_i) |
                   (bus.upd_taken_i & (bus.upd_pred_target_i != bus.upd_target_i)));
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = bus.upd_taken_i ? bus.upd_target_i
                                    : bus.upd_pc_i + XLEN'(4);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: INIT sweeps the valid bits, RUN predicts and trains
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_idx;
    clr_en    = 1'b0;
    trn_en    = 1'b0;
    case (state)
      INIT: begin
        clr_en = 1'b1;
        if (sweep_idx == '1) begin
          state_nxt = RUN;
          sweep_nxt = '0;
        end else begin
          sweep_nxt = sweep_idx + IDX_W'(1);
        end
      end
      RUN: begin
        trn_en = brj_res;
      end
    endcase
    // flush restarts the sweep from either state and drops any training
    if (bus.flush_i) begin
      state_nxt = INIT;
      sweep_nxt = '0;
      trn_en    = 1'b0;
    end
    if (rst_i) begin
      trn_en = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Lookup (zero latency, no bypass of same-cycle training)
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              lk_taken;
  logic [XLEN-1:0]   lk_target;

  assign lk_idx = bus.if_pc_i[IDX_W+1:2];
  assign lk_tag = bus.if_pc_i[XLEN-1:IDX_W+2];

  always_comb begin
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = '0;
    if (state == RUN) begin
      lk_hit   = btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag);
      lk_taken = lk_hit & btb_cnt[lk_idx][CNT_W-1];
      if (lk_taken) begin
        lk_target = btb_tgt[lk_idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic [CNT_W-1:0]  up_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_dec;

  assign up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag = bus.upd_pc_i[XLEN-1:IDX_W+2];
  assign up_hit = btb_valid[up_idx] & (btb_tag[up_idx] == up_tag);
  assign up_cnt = btb_cnt[up_idx];

  always_comb begin
    cnt_inc = (up_cnt == CNT_MAX) ? up_cnt : up_cnt + CNT_W'(1);
    cnt_dec = (up_cnt == '0)      ? up_cnt : up_cnt - CNT_W'(1);
  end

  // clr_en (INIT) and trn_en (RUN) are mutually exclusive
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      btb_valid[sweep_idx] <= 1'b0;
    end
    if (trn_en) begin
      if (up_hit) begin
        if (bus.upd_taken_i) begin
          btb_cnt[up_idx] <= cnt_inc;
          btb_tgt[up_idx] <= bus.upd_target_i;
        end else begin
          btb_cnt[up_idx] <= cnt_dec;
        end
      end else if (bus.upd_taken_i) begin
        btb_valid[up_idx] <= 1'b1;
        btb_tag[up_idx]   <= up_tag;
        btb_tgt[up_idx]   <= bus.upd_target_i;
        btb_cnt[up_idx]   <= CNT_WEAK;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics (count in both states, wrap modulo 2^32)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      brj_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (brj_res) begin
        brj_cnt <= brj_cnt + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ready_o       = (state == RUN);
  assign bus.pred_hit_o    = lk_hit;
  assign bus.pred_taken_o  = lk_taken;
  assign bus.pred_target_o = lk_target;
  assign bus.mispredict_o  = mispredict;
  assign bus.redirect_pc_o = redirect_pc;
  assign bus.brj_cnt_o     = brj_cnt;
  assign bus.mispred_cnt_o = mispred_cnt;

  // word-aligned PCs: the byte offset bits carry no information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc_i[1:0], bus.upd_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam int unsigned N = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32)) bus ();

  branch_predict_unit #(
    .XLEN(32),
    .NUM_ENTRIES(N),
    .CNT_W(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: table keyed by word address, counters as plain ints,
  // whole-table clear plus a countdown of initialisation cycles.
  bit          mvalid [N];
  logic [29:0] mkey   [N];
  logic [31:0] mtgt   [N];
  int          mcnt   [N];
  int          init_left = N;
  logic [31:0] m_brj  = '0;
  logic [31:0] m_misp = '0;

  typedef struct {
    logic        v;
    logic        b;
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_misp;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'(pc[7:2]);
    return (init_left == 0) && mvalid[i] && (mkey[i] == pc[31:2]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    int i = int'(pc[7:2]);
    return m_hit(pc) && (mcnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    int i = int'(pc[7:2]);
    return m_taken(pc) ? mtgt[i] : 32'h0;
  endfunction

  function automatic bit m_misp_now();
    bit brj = bus.upd_valid_i && bus.upd_is_brj_i;
    return brj && ((bus.upd_pred_taken_i != bus.upd_taken_i) ||
                   (bus.upd_taken_i && (bus.upd_pred_target_i != bus.upd_target_i)));
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!m_misp_now()) return 32'h0;
    return bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + 32'd4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    init_left = N;
  endtask

  // Applies the effect of one rising edge, using the inputs held across it.
  task automatic model_update();
    bit brj = bus.upd_valid_i && bus.upd_is_brj_i;
    int i = int'(bus.upd_pc_i[7:2]);
    if (rst) begin
      model_clear();
      m_brj  = '0;
      m_misp = '0;
      return;
    end
    if (brj) m_brj++;
    if (m_misp_now()) m_misp++;
    if (bus.flush_i) begin
      model_clear();
    end else if (init_left > 0) begin
      init_left--;
    end else if (brj) begin
      if (mvalid[i] && mkey[i] == bus.upd_pc_i[31:2]) begin
        if (bus.upd_taken_i) begin
          mcnt[i] = (mcnt[i] < 3) ? mcnt[i] + 1 : 3;
          mtgt[i] = bus.upd_target_i;
        end else begin
          mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
        end
      end else if (bus.upd_taken_i) begin
        mvalid[i] = 1'b1;
        mkey[i]   = bus.upd_pc_i[31:2];
        mtgt[i]   = bus.upd_target_i;
        mcnt[i]   = 2;
      end
    end
  endtask

  task automatic check_outputs();
    check("ready",       bus.ready_o,       (init_left == 0));
    check("pred_hit",    bus.pred_hit_o,    m_hit(bus.if_pc_i));
    check("pred_taken",  bus.pred_taken_o,  m_taken(bus.if_pc_i));
    check("pred_target", bus.pred_target_o, m_target(bus.if_pc_i));
    check("mispredict",  bus.mispredict_o,  m_misp_now());
    check("redirect_pc", bus.redirect_pc_o, m_redirect());
    check("brj_cnt",     bus.brj_cnt_o,     m_brj);
    check("mispred_cnt", bus.mispred_cnt_o, m_misp);
  endtask

  // Inputs are set before calling; check at negedge, then advance one edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.flush_i           = 1'b0;
    bus.upd_valid_i       = 1'b0;
    bus.upd_is_brj_i      = 1'b0;
    bus.upd_pc_i          = '0;
    bus.upd_taken_i       = 1'b0;
    bus.upd_target_i      = '0;
    bus.upd_pred_taken_i  = 1'b0;
    bus.upd_pred_target_i = '0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    bus.upd_valid_i       = 1'b1;
    bus.upd_is_brj_i      = 1'b1;
    bus.upd_pc_i          = pc;
    bus.upd_taken_i       = t;
    bus.upd_target_i      = tgt;
    bus.upd_pred_taken_i  = pt;
    bus.upd_pred_target_i = ptgt;
  endtask

  // Update pc and look it up in the same cycle: lookup must show the
  // pre-update direction.
  task automatic upd_chk(input logic [31:0] pc, input logic t, input logic exp_before,
                         input string nm);
    set_upd(pc, t, 32'h40, exp_before, 32'h40);
    bus.if_pc_i = pc;
    #1;
    check(nm, bus.pred_taken_o, exp_before);
    cycle();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] hi;
    case ($urandom_range(0, 3))
      0:       hi = 32'h0000_0000;
      1:       hi = 32'h0000_0100;
      2:       hi = 32'hFFFF_FF00;
      default: hi = 32'h1234_5600;
    endcase
    return hi | (32'($urandom_range(0, 3)) << 2);
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 2))
      0:       return 32'h0000_0040;
      1:       return 32'h0000_0080;
      default: return 32'h0000_1000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] misp_before;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0504, 1'b1, 32'h0000_0500};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0500, 1'b0, 32'h0000_0999, 1'b0, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0404, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0408};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0404, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0404, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h8000_0000};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0408, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0010};

    // ---- reset sequence
    idle();
    bus.if_pc_i = 32'h100;
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    rst = 1'b0;
    #1;
    check("rst_ready",   bus.ready_o,       32'h0);
    check("rst_hit",     bus.pred_hit_o,    32'h0);
    check("rst_brj",     bus.brj_cnt_o,     32'h0);
    check("rst_mispred", bus.mispred_cnt_o, 32'h0);
    for (int i = 0; i < int'(N); i++) begin
      bus.if_pc_i = $urandom;
      #1;
      check("init_ready_low", bus.ready_o, 32'h0);
      cycle();
    end
    #1;
    check("init_ready_high", bus.ready_o, 32'h1);

    // ---- allocate then predict
    set_upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    bus.if_pc_i = 32'h100;
    #1;
    check("alloc_mispredict", bus.mispredict_o,  32'h1);
    check("alloc_redirect",   bus.redirect_pc_o, 32'h40);
    check("alloc_no_bypass",  bus.pred_hit_o,    32'h0);
    cycle();
    idle();
    #1;
    check("alloc_hit",    bus.pred_hit_o,    32'h1);
    check("alloc_taken",  bus.pred_taken_o,  32'h1);
    check("alloc_target", bus.pred_target_o, 32'h40);
    cycle();

    // ---- hysteresis and saturation (counter starts weakly taken)
    upd_chk(32'h100, 1'b0, 1'b1, "hys_nt1");
    upd_chk(32'h100, 1'b0, 1'b0, "hys_nt2");
    upd_chk(32'h100, 1'b1, 1'b0, "hys_t1");
    upd_chk(32'h100, 1'b1, 1'b0, "hys_t2");
    upd_chk(32'h100, 1'b1, 1'b1, "hys_t3");
    upd_chk(32'h100, 1'b1, 1'b1, "hys_t4_sat");
    upd_chk(32'h100, 1'b0, 1'b1, "hys_nt_from3");
    upd_chk(32'h100, 1'b0, 1'b1, "hys_nt_from2");
    idle();
    #1;
    check("hys_final", bus.pred_taken_o, 32'h0);
    cycle();

    // ---- alias eviction
    set_upd(32'h200, 1'b1, 32'h80, 1'b0, 32'h0);
    cycle();
    idle();
    bus.if_pc_i = 32'h100;
    #1;
    check("alias_evicted", bus.pred_hit_o, 32'h0);
    cycle();
    bus.if_pc_i = 32'h200;
    #1;
    check("alias_new_tgt", bus.pred_target_o, 32'h80);
    cycle();

    // ---- not-taken mispredict with PC wrap
    misp_before = m_misp;
    set_upd(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1, 32'h1234);
    #1;
    check("wrap_mispredict", bus.mispredict_o,  32'h1);
    check("wrap_redirect",   bus.redirect_pc_o, 32'h0);
    cycle();
    idle();
    #1;
    check("wrap_mispred_cnt", bus.mispred_cnt_o, misp_before + 32'd1);

    // ---- table-driven resolution vectors
    foreach (vecs[k]) begin
      bus.upd_valid_i       = vecs[k].v;
      bus.upd_is_brj_i      = vecs[k].b;
      bus.upd_pc_i          = vecs[k].pc;
      bus.upd_taken_i       = vecs[k].t;
      bus.upd_target_i      = vecs[k].tgt;
      bus.upd_pred_taken_i  = vecs[k].pt;
      bus.upd_pred_target_i = vecs[k].ptgt;
      bus.if_pc_i           = vecs[k].pc;
      #1;
      check($sformatf("vec%0d_mispredict", k), bus.mispredict_o,  vecs[k].e_misp);
      check($sformatf("vec%0d_redirect", k),   bus.redirect_pc_o, vecs[k].e_redir);
      cycle();
    end
    idle();

    // ---- flush in RUN with a same-cycle update, then flush mid-sweep
    bus.flush_i = 1'b1;
    set_upd(32'h300, 1'b1, 32'h44, 1'b0, 32'h0);
    bus.if_pc_i = 32'h300;
    cycle();
    idle();
    for (int i = 0; i < 30; i++) begin
      #1;
      check("flush_ready_low", bus.ready_o, 32'h0);
      cycle();
    end
    bus.flush_i = 1'b1;
    #1;
    check("reflush_ready_low", bus.ready_o, 32'h0);
    cycle();
    bus.flush_i = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      #1;
      check("reflush_sweep_low", bus.ready_o, 32'h0);
      cycle();
    end
    #1;
    check("reflush_ready_high", bus.ready_o, 32'h1);
    check("flush_upd_dropped",  bus.pred_hit_o, 32'h0);
    cycle();

    // ---- randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = rand_pc();
      rst                  = ($urandom_range(0, 999) < 3);
      bus.flush_i          = ($urandom_range(0, 99) == 0);
      bus.upd_valid_i      = ($urandom_range(0, 9) < 8);
      bus.upd_is_brj_i     = ($urandom_range(0, 9) < 8);
      bus.upd_pc_i         = pc;
      bus.upd_taken_i      = $urandom_range(0, 1);
      bus.upd_target_i     = rand_tgt();
      if ($urandom_range(0, 1) == 1) begin
        bus.upd_pred_taken_i  = m_taken(pc);
        bus.upd_pred_target_i = m_target(pc);
      end else begin
        bus.upd_pred_taken_i  = $urandom_range(0, 1);
        bus.upd_pred_target_i = rand_tgt();
      end
      bus.if_pc_i = ($urandom_range(0, 1) == 1) ? pc : rand_pc();
      cycle();
    end
    rst = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
